// File: rtl/fifo_echo_controller_pkg.sv
// rtl/fifo_echo_controller_pkg.sv - shared types and constants for the echo FIFO controller
package fifo_echo_controller_pkg;

   localparam int unsigned IDLE_W = 16;
   localparam logic [7:0] DEFAULT_FLUSH_CHAR = 8'h0D;

   typedef enum logic [2:0] {
      ST_CLEAR   = 3'd0,
      ST_COLLECT = 3'd1,
      ST_POP     = 3'd2,
      ST_LATCH   = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT    = 3'd5
   } state_e;

   function automatic logic is_drain(input state_e s);
      return (s == ST_POP) || (s == ST_LATCH) || (s == ST_SEND) || (s == ST_WAIT);
   endfunction

endpackage

// File: rtl/fifo_echo_controller_idle_timer.sv
// rtl/fifo_echo_controller_idle_timer.sv - saturating RX-silence counter
// Restart loads 1 so the count equals the cycles elapsed since the restarting event.
module idle_timer
   import fifo_echo_controller_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              enable,
   input  logic [IDLE_W-1:0] limit,
   output logic              expired
);

   logic [IDLE_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (restart) begin
         count_d = IDLE_W'(1);
      end else if (enable && (count_q != '1)) begin
         count_d = count_q + IDLE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q >= limit);

endmodule

// File: rtl/fifo_echo_controller.sv
// rtl/fifo_echo_controller.sv - collects RX bytes into an edge-triggered FIFO and drains them to TX
module fifo_echo_controller
   import fifo_echo_controller_pkg::*;
#(
   parameter int unsigned              FIFO_SIZE    = 8,
   parameter int unsigned              DATA_WIDTH   = 8,
   parameter logic [DATA_WIDTH-1:0]    FLUSH_CHAR   = DATA_WIDTH'(DEFAULT_FLUSH_CHAR),
   parameter logic [IDLE_W-1:0]        IDLE_TIMEOUT = 16'd50000,
   localparam int unsigned             LEVEL_W      = $clog2(FIFO_SIZE + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_overrun,
   output logic                  fifo_push,
   output logic                  fifo_pop,
   output logic                  fifo_clear,
   output logic [DATA_WIDTH-1:0] fifo_in_data,
   input  logic [DATA_WIDTH-1:0] fifo_out_data,
   input  logic                  fifo_ready,
   output logic                  tx_start,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_busy,
   output logic [LEVEL_W-1:0]    level,
   output logic                  busy
);

   localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_SIZE);

   state_e                state_q, state_d;
   logic                  fifo_push_q, fifo_push_d;
   logic                  fifo_pop_q, fifo_pop_d;
   logic                  fifo_clear_q, fifo_clear_d;
   logic [DATA_WIDTH-1:0] fifo_in_data_q, fifo_in_data_d;
   logic                  tx_start_q, tx_start_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  rx_overrun_q, rx_overrun_d;
   logic [LEVEL_W-1:0]    level_q, level_d;
   logic                  busy_q, busy_d;
   logic                  wait_blank_q, wait_blank_d;

   logic accept, drain_go, flush_hit, full_hit, idle_hit, idle_expired;

   idle_timer u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (rx_valid || (state_q != ST_COLLECT)),
      .enable  (state_q == ST_COLLECT),
      .limit   (IDLE_TIMEOUT),
      .expired (idle_expired)
   );

   // Full waits for the push strobe to drop so the FIFO sees a low cycle before the pop edge.
   assign flush_hit = fifo_push_q && (fifo_in_data_q == FLUSH_CHAR);
   assign full_hit  = !fifo_push_q && (level_q == FULL_LEVEL);
   assign idle_hit  = idle_expired && (level_q != '0) && !rx_valid;
   assign drain_go  = (state_q == ST_COLLECT) && (flush_hit || full_hit || idle_hit);
   assign accept    = (state_q == ST_COLLECT) && rx_valid && fifo_ready &&
                      (level_q < FULL_LEVEL) && !fifo_push_q && !drain_go;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_CLEAR;
         fifo_push_q    <= 1'b0;
         fifo_pop_q     <= 1'b0;
         fifo_clear_q   <= 1'b1;
         fifo_in_data_q <= '0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= '0;
         rx_overrun_q   <= 1'b0;
         level_q        <= '0;
         busy_q         <= 1'b0;
         wait_blank_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         fifo_push_q    <= fifo_push_d;
         fifo_pop_q     <= fifo_pop_d;
         fifo_clear_q   <= fifo_clear_d;
         fifo_in_data_q <= fifo_in_data_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
         rx_overrun_q   <= rx_overrun_d;
         level_q        <= level_d;
         busy_q         <= busy_d;
         wait_blank_q   <= wait_blank_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR:   state_d = ST_COLLECT;
         ST_COLLECT: if (drain_go) state_d = ST_POP;
         ST_POP:     state_d = ST_LATCH;
         ST_LATCH:   state_d = ST_SEND;
         ST_SEND:    if (tx_start_q) state_d = ST_WAIT;
         ST_WAIT: begin
            if (!wait_blank_q && !tx_busy) begin
               state_d = (level_q != '0) ? ST_POP : ST_COLLECT;
            end
         end
         default:    state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      fifo_clear_d   = (state_d == ST_CLEAR);
      fifo_push_d    = accept;
      fifo_in_data_d = accept ? rx_data : fifo_in_data_q;
      fifo_pop_d     = (state_d == ST_POP);
      rx_overrun_d   = rx_valid && !accept;
      tx_data_d      = (state_q == ST_LATCH) ? fifo_out_data : tx_data_q;
      tx_start_d     = (state_d == ST_SEND) && !tx_start_q && !tx_busy;
      busy_d         = is_drain(state_d);
      wait_blank_d   = (state_d == ST_WAIT) && (state_q != ST_WAIT);
      level_d        = level_q;
      if (accept) begin
         level_d = level_q + LEVEL_W'(1);
      end else if (fifo_pop_d) begin
         level_d = level_q - LEVEL_W'(1);
      end
   end

   assign fifo_push    = fifo_push_q;
   assign fifo_pop     = fifo_pop_q;
   assign fifo_clear   = fifo_clear_q;
   assign fifo_in_data = fifo_in_data_q;
   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign rx_overrun   = rx_overrun_q;
   assign level        = level_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_echo_controller.sv
// tb/tb_fifo_echo_controller.sv - directed bench with FIFO stub and TX scoreboard
module tb_fifo_echo_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_overrun;
   logic       fifo_push, fifo_pop, fifo_clear;
   logic [7:0] fifo_in_data;
   logic [7:0] stub_out = 8'h00;
   logic       fifo_ready = 1'b1;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy = 1'b0;
   logic [3:0] level;
   logic       busy;

   always #5 clk = ~clk;

   fifo_echo_controller #(
      .FIFO_SIZE    (8),
      .DATA_WIDTH   (8),
      .FLUSH_CHAR   (8'h0D),
      .IDLE_TIMEOUT (16'd20)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_overrun    (rx_overrun),
      .fifo_push     (fifo_push),
      .fifo_pop      (fifo_pop),
      .fifo_clear    (fifo_clear),
      .fifo_in_data  (fifo_in_data),
      .fifo_out_data (stub_out),
      .fifo_ready    (fifo_ready),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .tx_busy       (tx_busy),
      .level         (level),
      .busy          (busy)
   );

   int checks = 0;
   int errors = 0;
   int exp_ovr = 0;
   int ovr_seen = 0;
   int tx_seen = 0;
   bit started = 1'b0;
   bit push_prev = 1'b0;
   bit pop_prev = 1'b0;
   bit busy_prev = 1'b0;
   logic [7:0] stub_q[$];
   logic [7:0] exp_tx[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // The stub plays the attached FIFO; the scoreboard holds bytes the bench expects on TX.
   always @(negedge clk) begin
      if (started) begin
         if (fifo_clear) stub_q.delete();
         if (fifo_push) stub_q.push_back(fifo_in_data);
         if (fifo_pop && stub_q.size() > 0) stub_out = stub_q.pop_front();
         check("level_vs_store", int'(level), stub_q.size());
         check("push_pop_exclusive", int'(fifo_push && fifo_pop), 0);
         check("push_gap", int'(fifo_push && push_prev), 0);
         check("pop_gap", int'(fifo_pop && pop_prev), 0);
         if (rx_overrun) ovr_seen++;
         if (tx_start) begin
            tx_seen++;
            check("tx_start_while_busy", int'(busy_prev), 0);
            check("tx_expected", int'(exp_tx.size() > 0), 1);
            if (exp_tx.size() > 0) check("tx_data_order", int'(tx_data), int'(exp_tx.pop_front()));
         end
         push_prev = fifo_push;
         pop_prev  = fifo_pop;
         busy_prev = tx_busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx(input logic [7:0] b, input bit acc);
      rx_valid = 1'b1;
      rx_data  = b;
      if (acc) exp_tx.push_back(b);
      else exp_ovr++;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((busy || level != 0) && k < 400) begin
         tick();
         k++;
      end
      check({name, "_drain_done"}, int'(busy || level != 0), 0);
      check({name, "_all_sent"}, exp_tx.size(), 0);
   endtask

   initial begin
      int k;
      // reset release
      repeat (3) tick();
      started = 1'b1;
      check("clear_in_reset", int'(fifo_clear), 1);
      check("level_in_reset", int'(level), 0);
      rst = 1'b0;
      check("clear_after_release", int'(fifo_clear), 1);
      tick();
      check("clear_one_cycle", int'(fifo_clear), 0);
      check("strobes_idle", int'({fifo_push, fifo_pop, tx_start, rx_overrun, busy}), 0);
      check("level_idle", int'(level), 0);
      tick();

      // terminator-driven drain
      rx(8'h41, 1'b1);
      check("push_41", int'(fifo_push), 1);
      check("in_data_41", int'(fifo_in_data), 8'h41);
      check("level_1", int'(level), 1);
      repeat (10) tick();
      rx(8'h42, 1'b1);
      repeat (10) tick();
      rx(8'h0D, 1'b1);
      check("push_0d", int'(fifo_push), 1);
      check("level_3", int'(level), 3);
      tick();
      check("pop_n2", int'(fifo_pop), 1);
      check("level_n2", int'(level), 2);
      check("busy_n2", int'(busy), 1);
      tick();
      check("latch_no_start", int'(tx_start), 0);
      tick();
      check("start_n4", int'(tx_start), 1);
      check("tx_data_n4", int'(tx_data), 8'h41);
      tick();
      check("blank_n5", int'(tx_start), 0);
      tick();
      check("no_pop_n6", int'(fifo_pop), 0);
      tick();
      check("pop_n7", int'(fifo_pop), 1);
      wait_drain("flush");

      // full trigger
      for (int i = 0; i < 8; i++) begin
         rx(8'h10 + 8'(i), 1'b1);
         if (i < 7) tick();
      end
      check("level_full", int'(level), 8);
      tick();
      check("full_pop_wait", int'(fifo_pop), 0);
      tick();
      check("full_pop", int'(fifo_pop), 1);
      wait_drain("full");

      // idle trigger
      repeat (3) tick();
      rx(8'h55, 1'b1);
      k = 1;
      while (!fifo_pop && k < 100) begin
         tick();
         k++;
      end
      check("idle_pop_delay", k, 21);
      wait_drain("idle");

      // overruns
      repeat (3) tick();
      rx(8'h31, 1'b1);
      rx(8'h32, 1'b0);
      check("ovr_back_to_back", int'(rx_overrun), 1);
      check("ovr_level", int'(level), 1);
      tick();
      check("ovr_one_pulse", int'(rx_overrun), 0);
      repeat (3) tick();
      rx(8'h0D, 1'b1);
      tick();
      rx(8'h77, 1'b0);
      check("ovr_drain", int'(rx_overrun), 1);
      check("ovr_drain_level", int'(level), 1);
      wait_drain("ovr");
      check("ovr_total", ovr_seen, exp_ovr);

      // stalled transmitter, then reset during WAIT
      repeat (3) tick();
      rx(8'h61, 1'b1);
      tick();
      rx(8'h0D, 1'b1);
      tx_busy = 1'b1;
      repeat (100) tick();
      check("stall_no_start", int'(tx_start), 0);
      check("stall_busy", int'(busy), 1);
      tx_busy = 1'b0;
      tick();
      check("stall_start", int'(tx_start), 1);
      check("stall_tx_data", int'(tx_data), 8'h61);
      tx_busy = 1'b1;
      repeat (2) tick();
      check("wait_hold_level", int'(level), 1);
      rst = 1'b1;
      exp_tx.delete();
      repeat (2) tick();
      rst = 1'b0;
      tx_busy = 1'b0;
      check("rst_clear", int'(fifo_clear), 1);
      check("rst_level", int'(level), 0);
      check("rst_strobes", int'({tx_start, busy, fifo_pop}), 0);
      tick();
      check("rst_clear_drop", int'(fifo_clear), 0);
      repeat (2) tick();
      check("tx_total", tx_seen, 15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
